mux_nto1_stage: RTL and testbench

Parametrised, registered N:1 operand-select stage for the datapath, the pipelined successor of the combinational 2:1 32-bit mux. It picks one of NUM_INPUTS words of WIDTH bits by a select field and registers the result behind a valid/ready handshake. A two-entry skid buffer sustains one word per cycle with fully registered `in_ready`. It sits between the ALU-source / write-back selection points and their consumers when those paths are pipelined.

---
 rtl/mux_nto1_stage_pkg.sv | 18 +
 rtl/mux_nto1_stage_if.sv | 30 +++
 rtl/mux_nto1_stage_mux.sv | 24 ++
 rtl/mux_nto1_stage.sv | 122 ++++++++++++
 tb/tb_mux_nto1_stage.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/mux_nto1_stage_pkg.sv
// Shared types and constants for the registered N:1 operand-select stage.
package mux_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int DEF_NUM_INPUTS = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   // A 2-input mux still needs one select bit, so clamp the width at 1.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_nto1_stage_if.sv
// Valid/ready bus of the select stage: producer side, consumer side and flush.
interface mux_nto1_stage_if
   import mux_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int NUM_INPUTS = DEF_NUM_INPUTS
);
   localparam int SEL_WIDTH = sel_width(NUM_INPUTS);

   logic                        flush;
   logic                        in_valid;
   logic                        in_ready;
   logic [NUM_INPUTS*WIDTH-1:0] in_data;
   logic [SEL_WIDTH-1:0]        in_sel;
   logic                        out_valid;
   logic                        out_ready;
   logic [WIDTH-1:0]            out_data;
   logic                        out_sel_err;

   modport slave (
      input  flush, in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, out_data, out_sel_err
   );

   modport master (
      output flush, in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, out_data, out_sel_err
   );

endinterface

// File: rtl/mux_nto1_stage_mux.sv
// Combinational N:1 word selector; out-of-range selects give zero and raise o_err.
module mux_nto1 #(
   parameter int WIDTH      = 32,
   parameter int NUM_INPUTS = 2,
   parameter int SEL_WIDTH  = 1
) (
   input  logic [NUM_INPUTS*WIDTH-1:0] i_data,
   input  logic [SEL_WIDTH-1:0]        i_sel,
   output logic [WIDTH-1:0]            o_data,
   output logic                        o_err
);

   always_comb begin
      o_data = '0;
      o_err  = 1'b1;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (i_sel == SEL_WIDTH'(i)) begin
            o_data = i_data[i*WIDTH +: WIDTH];
            o_err  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_nto1_stage.sv
// Registered N:1 select stage: selector feeding a main/skid register pair behind
// a valid/ready handshake with fully registered in_ready.
module mux_nto1_stage
   import mux_pkg::*;
#(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int NUM_INPUTS = DEF_NUM_INPUTS
) (
   input  logic             clock,
   input  logic             reset,
   mux_nto1_stage_if.slave  bus
);

   localparam int SEL_WIDTH = sel_width(NUM_INPUTS);

   localparam logic [1:0] S_EMPTY = EMPTY;
   localparam logic [1:0] S_ONE   = ONE;
   localparam logic [1:0] S_TWO   = TWO;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;
   logic             r_main_err;
   logic             r_skid_err;
   logic             r_in_ready;
   logic             r_out_valid;

   logic [WIDTH-1:0] w_word;
   logic             w_err;
   logic             w_acc;
   logic             w_pop;
   logic [1:0]       w_nxt;
   logic             w_ld_main_in;
   logic             w_ld_main_skid;
   logic             w_ld_skid;

   mux_nto1 #(
      .WIDTH      (WIDTH),
      .NUM_INPUTS (NUM_INPUTS),
      .SEL_WIDTH  (SEL_WIDTH)
   ) u_sel (
      .i_data (bus.in_data),
      .i_sel  (bus.in_sel),
      .o_data (w_word),
      .o_err  (w_err)
   );

   assign w_acc = bus.in_valid && r_in_ready;
   assign w_pop = r_out_valid && bus.out_ready;

   always_comb begin
      w_nxt          = r_state;
      w_ld_main_in   = 1'b0;
      w_ld_main_skid = 1'b0;
      w_ld_skid      = 1'b0;
      case (r_state)
         S_EMPTY: begin
            if (w_acc) begin
               w_nxt        = S_ONE;
               w_ld_main_in = 1'b1;
            end
         end
         S_ONE: begin
            if (w_acc && w_pop) begin
               w_ld_main_in = 1'b1;
            end else if (w_acc) begin
               w_nxt     = S_TWO;
               w_ld_skid = 1'b1;
            end else if (w_pop) begin
               w_nxt = S_EMPTY;
            end
         end
         S_TWO: begin
            if (w_pop) begin
               w_nxt          = S_ONE;
               w_ld_main_skid = 1'b1;
            end
         end
         default: w_nxt = S_EMPTY;
      endcase
      // Flush drops everything, including a word offered this same cycle.
      if (bus.flush) begin
         w_nxt          = S_EMPTY;
         w_ld_main_in   = 1'b0;
         w_ld_main_skid = 1'b0;
         w_ld_skid      = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_EMPTY;
         r_main      <= '0;
         r_main_err  <= 1'b0;
         r_skid      <= '0;
         r_skid_err  <= 1'b0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_nxt;
         r_in_ready  <= (w_nxt != S_TWO);
         r_out_valid <= (w_nxt != S_EMPTY);
         if (w_ld_main_in) begin
            r_main     <= w_word;
            r_main_err <= w_err;
         end else if (w_ld_main_skid) begin
            r_main     <= r_skid;
            r_main_err <= r_skid_err;
         end
         if (w_ld_skid) begin
            r_skid     <= w_word;
            r_skid_err <= w_err;
         end
      end
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.out_valid   = r_out_valid;
   assign bus.out_data    = r_main;
   assign bus.out_sel_err = r_main_err;

endmodule

// File: tb/tb_mux_nto1_stage.sv
// Bench for mux_nto1_stage: directed cases on 4:1/3:1 x 32-bit instances and a
// randomized run on a 5:1 x 8-bit instance against a queue-based reference.
module tb_mux_nto1_stage;

   logic clock = 1'b0;
   logic rst   = 1'b1;
   logic rst_a = 1'b1;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   mux_nto1_stage_if #(.WIDTH(32), .NUM_INPUTS(4)) ifa ();
   mux_nto1_stage_if #(.WIDTH(32), .NUM_INPUTS(3)) ifb ();
   mux_nto1_stage_if #(.WIDTH(8),  .NUM_INPUTS(5)) ifc ();

   mux_nto1_stage #(.WIDTH(32), .NUM_INPUTS(4)) dut_a (.clock(clock), .reset(rst_a), .bus(ifa.slave));
   mux_nto1_stage #(.WIDTH(32), .NUM_INPUTS(3)) dut_b (.clock(clock), .reset(rst),   .bus(ifb.slave));
   mux_nto1_stage #(.WIDTH(8),  .NUM_INPUTS(5)) dut_c (.clock(clock), .reset(rst),   .bus(ifc.slave));

   typedef struct {
      logic [7:0] d;
      logic       e;
   } ent_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic [31:0] cap[$];
      logic [31:0] wd;
      int          sent;
      int          stall;
      ent_t        q[$];
      ent_t        ex;
      logic [7:0]  w[5];
      logic [2:0]  sel;
      logic        prev_stall;
      logic [7:0]  prev_d;
      logic        prev_e;
      logic        acc;
      logic        pop;

      ifa.flush = 0; ifa.in_valid = 0; ifa.in_data = '0; ifa.in_sel = '0; ifa.out_ready = 0;
      ifb.flush = 0; ifb.in_valid = 0; ifb.in_data = '0; ifb.in_sel = '0; ifb.out_ready = 0;
      ifc.flush = 0; ifc.in_valid = 0; ifc.in_data = '0; ifc.in_sel = '0; ifc.out_ready = 0;

      step(); step();
      chk("rst_valid", ifa.out_valid, 0);
      chk("rst_ready", ifa.in_ready, 1);
      chk("rst_data", ifa.out_data, 0);
      chk("rst_err", ifa.out_sel_err, 0);
      rst = 0; rst_a = 0;
      step();

      // 4:1 select of input 2
      ifa.in_data  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      ifa.in_sel   = 2'd2;
      ifa.in_valid = 1; ifa.out_ready = 1;
      step();
      ifa.in_valid = 0;
      chk("sel2_valid", ifa.out_valid, 1);
      chk("sel2_data", ifa.out_data, 32'h3333_3333);
      chk("sel2_err", ifa.out_sel_err, 0);
      step();
      chk("sel2_drain", ifa.out_valid, 0);

      // 3:1 with out-of-range select
      ifb.in_data  = {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
      ifb.in_sel   = 2'd3;
      ifb.in_valid = 1; ifb.out_ready = 1;
      step();
      chk("oor_valid", ifb.out_valid, 1);
      chk("oor_data", ifb.out_data, 0);
      chk("oor_err", ifb.out_sel_err, 1);
      ifb.in_sel = 2'd1;
      step();
      ifb.in_valid = 0;
      chk("b_sel1_data", ifb.out_data, 32'hBBBB_BBBB);
      chk("b_sel1_err", ifb.out_sel_err, 0);

      // 8-word stream, consumer stalls in cycles 3..5
      sent = 0; stall = 0;
      ifa.in_sel = 2'd0;
      for (int c = 0; c < 40 && cap.size() < 8; c++) begin
         ifa.in_valid  = (sent < 8);
         ifa.in_data   = {$urandom, $urandom, $urandom, 32'hA000_0000 + 32'(sent)};
         ifa.out_ready = !(c >= 3 && c <= 5);
         #1;
         if (!ifa.in_ready) stall++;
         if (ifa.out_valid && ifa.out_ready) cap.push_back(ifa.out_data);
         if (ifa.in_valid && ifa.in_ready) sent++;
         step();
      end
      ifa.in_valid = 0;
      chk("stream_count", cap.size(), 8);
      for (int i = 0; i < 8; i++) begin
         wd = (i < cap.size()) ? cap[i] : 32'hDEAD_BEEF;
         chk($sformatf("stream_word%0d", i), wd, 32'hA000_0000 + 32'(i));
      end
      chk("stream_stall_cycles", stall, 3);

      // flush while full
      ifa.out_ready = 0; ifa.in_valid = 1;
      ifa.in_data[31:0] = 32'hF000_0001; step();
      ifa.in_data[31:0] = 32'hF000_0002; step();
      chk("full_ready", ifa.in_ready, 0);
      ifa.flush = 1; ifa.in_data[31:0] = 32'hF000_0003; step();
      ifa.flush = 0;
      chk("flush2_valid", ifa.out_valid, 0);
      chk("flush2_ready", ifa.in_ready, 1);
      // flush with a same-cycle accept in ONE
      ifa.in_data[31:0] = 32'hF000_0004; step();
      ifa.flush = 1; ifa.in_data[31:0] = 32'hF000_0005; step();
      ifa.flush = 0; ifa.in_valid = 0; ifa.out_ready = 1;
      chk("flush1_valid", ifa.out_valid, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("flush_stays_empty", ifa.out_valid, 0);
      end
      ifa.in_valid = 1; ifa.in_data[31:0] = 32'h6060_6060; step();
      ifa.in_valid = 0;
      chk("post_flush_data", ifa.out_data, 32'h6060_6060);

      // asynchronous reset between edges
      ifa.in_valid = 1; ifa.out_ready = 0; ifa.in_data[31:0] = 32'h7777_7777; step();
      ifa.in_data[31:0] = 32'h8888_8888; step();
      #2 rst_a = 1;
      #1;
      chk("arst_valid", ifa.out_valid, 0);
      chk("arst_data", ifa.out_data, 0);
      chk("arst_ready", ifa.in_ready, 1);
      chk("arst_err", ifa.out_sel_err, 0);
      ifa.in_valid = 0;
      #1 rst_a = 0;
      step();

      // randomized 5:1 x 8-bit against a FIFO of at most two words
      prev_stall = 0; prev_d = '0; prev_e = 0;
      for (int n = 0; n < 10000; n++) begin
         for (int i = 0; i < 5; i++) w[i] = 8'($urandom);
         sel = 3'($urandom_range(0, 7));
         for (int i = 0; i < 5; i++) ifc.in_data[i*8 +: 8] = w[i];
         ifc.in_sel    = sel;
         ifc.in_valid  = ($urandom_range(0, 3) != 0);
         ifc.out_ready = ($urandom_range(0, 3) != 0);
         ifc.flush     = ($urandom_range(0, 63) == 0);
         @(negedge clock);
         chk("rnd_valid", ifc.out_valid, q.size() > 0);
         chk("rnd_ready", ifc.in_ready, q.size() < 2);
         if (q.size() > 0) begin
            chk("rnd_data", ifc.out_data, q[0].d);
            chk("rnd_err", ifc.out_sel_err, q[0].e);
         end
         if (prev_stall) begin
            chk("rnd_stable_data", ifc.out_data, prev_d);
            chk("rnd_stable_err", ifc.out_sel_err, prev_e);
         end
         prev_stall = ifc.out_valid && !ifc.out_ready;
         prev_d = ifc.out_data; prev_e = ifc.out_sel_err;
         ex.d = (sel < 5) ? w[sel] : 8'h00;
         ex.e = (sel >= 5);
         acc = ifc.in_valid && (q.size() < 2) && !ifc.flush;
         pop = (q.size() > 0) && ifc.out_ready;
         @(posedge clock);
         if (pop) void'(q.pop_front());
         if (ifc.flush) q.delete();
         else if (acc) q.push_back(ex);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
